// File: rtl/irq_prio_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: register map,
// FSM state encoding and the priority-rank helper used by rotated priority.
package irq_prio_ctrl_pkg;

    localparam logic [2:0] ADDR_VEC     = 3'b000;
    localparam logic [2:0] ADDR_ISR     = 3'b001;
    localparam logic [2:0] ADDR_PEND    = 3'b010;
    localparam logic [2:0] ADDR_CTRL_RD = 3'b011;
    localparam logic [2:0] ADDR_EOI     = 3'b100;
    localparam logic [2:0] ADDR_CTRL_WR = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_t;

    // Rank 0 is the highest priority; the source at index ptr holds rank 0.
    function automatic int prio_rank(input int k, input int ptr, input int n);
        int r;
        r = k - ptr;
        if (r < 0) r = r + n;
        return r;
    endfunction

endpackage

// File: rtl/irq_prio_ctrl_prio_enc.sv
// Priority encoder: index 0 highest, or starting from ptr when PRIO_ROTATE_EN
// is defined. Returns whether any request is set and the winning index.
module prio_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
`ifdef PRIO_ROTATE_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
`ifdef PRIO_ROTATE_EN
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
`else
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt priority controller with in-service tracking, optional nesting
// and, when PRIO_ROTATE_EN is defined, rotating priority updated on EOI.
module irq_prio_ctrl
    import irq_prio_ctrl_pkg::*;
#(
    parameter int BW = 7,
    parameter int IW = 3
) (
    input  logic          MCLK,
    input  logic          nRESET,
    input  logic [BW:0]   IRQ_PEND,
    input  logic          CS,
    input  logic          nRW,
    input  logic [2:0]    ADD,
    input  logic [BW:0]   DI,
    output logic [BW:0]   DO,
    output logic          nIRQ
);

    localparam int N = BW + 1;

    logic [BW:0]   isr;
    logic [BW:0]   cand;
    logic [BW:0]   elig;
    logic [BW:0]   higher;
    logic          nest;
    logic          rd_prev;
    logic          is_read;
    logic          is_write;
    logic          ack;
    logic          eoi_ok;
    logic          ctrl_wr;
    logic          vec_valid;
    logic          isr_valid;
    logic [IW-1:0] vec_idx;
    logic [IW-1:0] isr_idx;
    logic [IW-1:0] eoi_idx;
    irq_state_t    state;
    irq_state_t    state_nxt;
`ifdef PRIO_ROTATE_EN
    logic [IW-1:0] rot_ptr;
`endif

    assign is_read  = CS & ~nRW;
    assign is_write = CS & nRW;
    assign ack      = is_read & (ADD == ADDR_VEC) & ~rd_prev;
    assign ctrl_wr  = is_write & (ADD == ADDR_CTRL_WR);
    assign eoi_idx  = DI[IW-1:0];
    assign eoi_ok   = is_write && (ADD == ADDR_EOI) && (int'(eoi_idx) < N) && isr[eoi_idx];
    assign cand     = IRQ_PEND & ~isr;

    // Sources that outrank the highest in-service source may nest over it.
    always_comb begin
        higher = '0;
        for (int k = 0; k < N; k++) begin
`ifdef PRIO_ROTATE_EN
            if (prio_rank(k, int'(rot_ptr), N) < prio_rank(int'(isr_idx), int'(rot_ptr), N))
                higher[k] = 1'b1;
`else
            if (k < int'(isr_idx))
                higher[k] = 1'b1;
`endif
        end
    end

    always_comb begin
        elig = '0;
        if (!isr_valid)
            elig = cand;
        else if (nest)
            elig = cand & higher;
    end

    prio_enc #(.N(N), .IW(IW)) u_vec_enc (
        .req   (elig),
`ifdef PRIO_ROTATE_EN
        .ptr   (rot_ptr),
`endif
        .valid (vec_valid),
        .idx   (vec_idx)
    );

    prio_enc #(.N(N), .IW(IW)) u_isr_enc (
        .req   (isr),
`ifdef PRIO_ROTATE_EN
        .ptr   (rot_ptr),
`endif
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    // A read held across several edges acknowledges only on its first edge.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            isr     <= '0;
            nest    <= 1'b0;
            rd_prev <= 1'b0;
`ifdef PRIO_ROTATE_EN
            rot_ptr <= '0;
`endif
        end else begin
            rd_prev <= is_read;
            if (ack && vec_valid)
                isr[vec_idx] <= 1'b1;
            if (eoi_ok) begin
                isr[eoi_idx] <= 1'b0;
`ifdef PRIO_ROTATE_EN
                rot_ptr <= (int'(eoi_idx) == N - 1) ? '0 : eoi_idx + 1'b1;
`endif
            end
            if (ctrl_wr)
                nest <= DI[0];
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (elig != '0) state_nxt = ST_REQ;
            ST_REQ:  if (elig == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign nIRQ = (state == ST_IDLE);

    always_comb begin
        DO = '0;
        if (is_read) begin
            case (ADD)
                ADDR_VEC: begin
                    DO[BW]     = vec_valid;
                    DO[IW-1:0] = vec_idx;
                end
                ADDR_ISR:     DO = isr;
                ADDR_PEND:    DO = IRQ_PEND;
                ADDR_CTRL_RD: DO[0] = nest;
                default:      DO = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: rank-based reference model compared
// every cycle, plus hand-computed directed checks. Honours PRIO_ROTATE_EN.
module tb_irq_prio_ctrl;

    localparam int BW = 7;
    localparam int IW = 3;
    localparam int N  = BW + 1;

    logic          MCLK     = 1'b0;
    logic          nRESET   = 1'b0;
    logic          CS       = 1'b0;
    logic          nRW      = 1'b0;
    logic [2:0]    ADD      = 3'b000;
    logic [BW:0]   IRQ_PEND = '0;
    logic [BW:0]   DI       = '0;
    logic [BW:0]   DO;
    logic          nIRQ;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [BW:0] m_isr;
    logic        m_nest;
    logic        m_prev_rd;
    logic        m_nirq;
    int          m_ptr;
    logic [BW:0] rd;

    always #5 MCLK = ~MCLK;

    irq_prio_ctrl #(.BW(BW), .IW(IW)) dut (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .IRQ_PEND (IRQ_PEND),
        .CS       (CS),
        .nRW      (nRW),
        .ADD      (ADD),
        .DI       (DI),
        .DO       (DO),
        .nIRQ     (nIRQ)
    );

    function automatic int rank_of(input int k, input int p);
        return (k - p + N) % N;
    endfunction

    function automatic int top_of(input logic [BW:0] v, input int p);
        int best = -1;
        for (int k = 0; k < N; k++)
            if (v[k] && (best < 0 || rank_of(k, p) < rank_of(best, p)))
                best = k;
        return best;
    endfunction

    function automatic logic [BW:0] elig_of(input logic [BW:0] pend, input logic [BW:0] isr,
                                             input logic nest, input int p);
        logic [BW:0] c = pend & ~isr;
        logic [BW:0] r = '0;
        int t;
        if (isr == '0) return c;
        if (!nest) return '0;
        t = top_of(isr, p);
        for (int k = 0; k < N; k++)
            if (c[k] && rank_of(k, p) < rank_of(t, p)) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [BW:0] exp_do();
        logic [BW:0] v = '0;
        int t;
        if (!(CS && !nRW)) return '0;
        case (ADD)
            3'd0: begin
                t = top_of(elig_of(IRQ_PEND, m_isr, m_nest, m_ptr), m_ptr);
                if (t >= 0) begin
                    v[BW]     = 1'b1;
                    v[IW-1:0] = t[IW-1:0];
                end
            end
            3'd1: v = m_isr;
            3'd2: v = IRQ_PEND;
            3'd3: v[0] = m_nest;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Reference model: state advanced from the inputs seen at each edge.
    always @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            m_isr     <= '0;
            m_nest    <= 1'b0;
            m_prev_rd <= 1'b0;
            m_nirq    <= 1'b1;
            m_ptr     <= 0;
        end else begin
            m_prev_rd <= CS && !nRW;
            m_nirq    <= (elig_of(IRQ_PEND, m_isr, m_nest, m_ptr) == '0);
            if (CS && !nRW && ADD == 3'd0 && !m_prev_rd
                && top_of(elig_of(IRQ_PEND, m_isr, m_nest, m_ptr), m_ptr) >= 0)
                m_isr[top_of(elig_of(IRQ_PEND, m_isr, m_nest, m_ptr), m_ptr)] <= 1'b1;
            if (CS && nRW && ADD == 3'd4 && int'(DI[IW-1:0]) < N && m_isr[DI[IW-1:0]]) begin
                m_isr[DI[IW-1:0]] <= 1'b0;
`ifdef PRIO_ROTATE_EN
                m_ptr <= (int'(DI[IW-1:0]) + 1) % N;
`endif
            end
            if (CS && nRW && ADD == 3'd6)
                m_nest <= DI[0];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge MCLK) begin
        if (cmp_en) begin
            check_output("model_nIRQ", 32'(nIRQ), 32'(m_nirq));
            check_output("model_DO", 32'(DO), 32'(exp_do()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [BW:0] pend);
        IRQ_PEND = pend;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [BW:0] d);
        CS  = 1'b1;
        nRW = 1'b0;
        ADD = a;
        @(negedge MCLK);
        #1 d = DO;
        step();
        CS  = 1'b0;
        ADD = 3'd0;
        step();
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [BW:0] d);
        CS  = 1'b1;
        nRW = 1'b1;
        ADD = a;
        DI  = d;
        step();
        CS  = 1'b0;
        nRW = 1'b0;
        ADD = 3'd0;
        DI  = '0;
    endtask

    initial begin
        step(2);
        check_output("reset_nIRQ", 32'(nIRQ), 32'd1);
        check_output("reset_DO", 32'(DO), 32'd0);
        cmp_en = 1'b1;
        nRESET = 1'b1;
        step();

        // First request with nesting off
        apply_stimulus(8'h24);
        check_output("nirq_before_latency", 32'(nIRQ), 32'd1);
        step();
        check_output("nirq_latency", 32'(nIRQ), 32'd0);
        read_reg(3'd0, rd);
        check_output("vec_0x24", 32'(rd), 32'h82);
        check_output("nirq_after_ack_nest0", 32'(nIRQ), 32'd1);
        read_reg(3'd1, rd);
        check_output("isr_after_ack", 32'(rd), 32'h04);
        apply_stimulus(8'h00);
        write_reg(3'd4, 8'd2);
        read_reg(3'd1, rd);
        check_output("isr_after_eoi2", 32'(rd), 32'h00);

        // Nested acknowledge
        write_reg(3'd6, 8'h01);
        read_reg(3'd3, rd);
        check_output("ctrl_nest", 32'(rd), 32'h01);
        apply_stimulus(8'h04);
        read_reg(3'd0, rd);
        check_output("vec_0x04", 32'(rd), 32'h82);
        apply_stimulus(8'h05);
        step();
        check_output("nirq_nested", 32'(nIRQ), 32'd0);
        read_reg(3'd0, rd);
        check_output("vec_nested", 32'(rd), 32'h80);
        read_reg(3'd1, rd);
        check_output("isr_nested", 32'(rd), 32'h05);
        apply_stimulus(8'h00);
        write_reg(3'd4, 8'd0);
        write_reg(3'd4, 8'd2);
        read_reg(3'd1, rd);
        check_output("isr_after_eoi_0_2", 32'(rd), 32'h00);

        // Pending drop before acknowledge
        apply_stimulus(8'h08);
        step();
        check_output("nirq_drop_req", 32'(nIRQ), 32'd0);
        apply_stimulus(8'h00);
        check_output("nirq_drop_same_cycle", 32'(nIRQ), 32'd0);
        step();
        check_output("nirq_drop_next", 32'(nIRQ), 32'd1);
        read_reg(3'd0, rd);
        check_output("vec_spurious", 32'(rd), 32'h00);
        read_reg(3'd1, rd);
        check_output("isr_spurious", 32'(rd), 32'h00);

        // Held read acknowledges once
        apply_stimulus(8'h03);
        CS = 1'b1; nRW = 1'b0; ADD = 3'd0;
        step(3);
        CS = 1'b0;
        step();
        read_reg(3'd1, rd);
        check_output("isr_held_read", 32'(rd), 32'h01);
        write_reg(3'd4, 8'd0);
        apply_stimulus(8'h02);
        CS = 1'b1; nRW = 1'b0; ADD = 3'd0;
        step();
        apply_stimulus(8'h03);
        step(2);
        CS = 1'b0;
        step();
        read_reg(3'd1, rd);
        check_output("isr_held_read_raise", 32'(rd), 32'h02);
        apply_stimulus(8'h00);
        write_reg(3'd4, 8'd1);

        // Ignored EOI and asynchronous reset
        apply_stimulus(8'h02);
        read_reg(3'd0, rd);
        check_output("vec_0x02", 32'(rd), 32'h81);
        write_reg(3'd4, 8'd5);
        read_reg(3'd1, rd);
        check_output("isr_eoi_unset", 32'(rd), 32'h02);
        apply_stimulus(8'h03);
        step();
        check_output("nirq_before_reset", 32'(nIRQ), 32'd0);
        nRESET = 1'b0;
        #1 check_output("nirq_async_reset", 32'(nIRQ), 32'd1);
        CS = 1'b1; nRW = 1'b0; ADD = 3'd1;
        #1 check_output("isr_in_reset", 32'(DO), 32'h00);
        ADD = 3'd3;
        #1 check_output("ctrl_in_reset", 32'(DO), 32'h00);
        CS = 1'b0; ADD = 3'd0;
        step();
        nRESET = 1'b1;
        step();
        read_reg(3'd1, rd);
        check_output("isr_after_reset", 32'(rd), 32'h00);

        // Priority after EOI of index 0 (rotated or fixed)
        read_reg(3'd0, rd);
        check_output("vec_first", 32'(rd), 32'h80);
        write_reg(3'd4, 8'd0);
        read_reg(3'd0, rd);
`ifdef PRIO_ROTATE_EN
        check_output("vec_rotated", 32'(rd), 32'h81);
`else
        check_output("vec_fixed", 32'(rd), 32'h80);
`endif
        apply_stimulus(8'h00);
        write_reg(3'd4, 8'd1);
        write_reg(3'd4, 8'd0);

        // Unmapped addresses
        read_reg(3'd5, rd);
        check_output("read_addr5", 32'(rd), 32'h00);
        write_reg(3'd5, 8'h01);
        write_reg(3'd7, 8'h01);
        read_reg(3'd3, rd);
        check_output("ctrl_unmapped_write", 32'(rd), 32'h00);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
